// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO console transmitter: address map and TX FSM states.
package mmio_pkg;

  localparam logic [31:0] MMIO_UART_ADDR = 32'hFFFF_0000;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BAUD_W         = 16;
  localparam int unsigned BIT_IDX_W      = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_byte_fifo.sv
// Byte FIFO with first-word-through read: dout is the head whenever empty is low.
module byte_fifo
  import mmio_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [BYTE_W-1:0] din,
  input  logic              pop,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, empty_q;
  logic              do_push_c, do_pop_c;

  // Protect against caller misuse: never push when full, never pop when empty.
  assign do_push_c = push && !full_q;
  assign do_pop_c  = pop && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Flags are registered from the next count so they stay in step with the pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_W'(DEPTH));
      empty_q  <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped console transmitter: decoded byte stores are queued and sent as 8N1 UART frames.
module mmio_uart_tx
  import mmio_pkg::*;
#(
  parameter logic [31:0] MMIO_ADDR    = MMIO_UART_ADDR,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_write,
  input  logic [7:0]  data,
  input  logic [31:0] data_address,
  output logic        tx,
  output logic        busy,
  output logic        fifo_full,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  tx_state_t            state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_IDX_W-1:0] bit_q, bit_d;
  logic [BYTE_W-1:0]    shreg_q, shreg_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 overflow_q, overflow_d;
  logic [7:0]           drop_q, drop_d;

  logic                 hit_c, push_c, drop_c, pop_c, baud_done_c;
  logic                 fifo_full_w, fifo_empty_w;
  logic [BYTE_W-1:0]    fifo_dout_w;

  // Full-address decode; full is the pre-edge value so a simultaneous pop cannot rescue a byte.
  assign hit_c       = data_write && (data_address == MMIO_ADDR);
  assign push_c      = hit_c && !fifo_full_w;
  assign drop_c      = hit_c && fifo_full_w;
  assign baud_done_c = (baud_q == '0);

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_c),
    .din   (data),
    .pop   (pop_c),
    .dout  (fifo_dout_w),
    .full  (fifo_full_w),
    .empty (fifo_empty_w)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    pop_c   = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty_w) begin
          pop_c   = 1'b1;
          shreg_d = fifo_dout_w;
          baud_d  = BAUD_RELOAD;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (baud_done_c) begin
          baud_d  = BAUD_RELOAD;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          state_d = DATA;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_done_c) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == BIT_IDX_W'(7)) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            // Shift so the next bit to send is always at shreg[1] when the current one ends.
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
            bit_d   = bit_q + BIT_IDX_W'(1);
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_done_c) begin
          if (!fifo_empty_w) begin
            pop_c   = 1'b1;
            shreg_d = fifo_dout_w;
            baud_d  = BAUD_RELOAD;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // Next-cycle occupancy is non-zero iff a push lands or the FIFO keeps an entry; a pop implies a frame starts.
  assign busy_d = (state_d != IDLE) || push_c || !fifo_empty_w;

  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (drop_c) begin
      overflow_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign fifo_full  = fifo_full_w;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: decode vectors, frame timing, back-to-back, overflow and saturation.
module tb_mmio_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] ADDR  = 32'hFFFF_0000;
  localparam int unsigned NVEC  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_write = 1'b0;
  logic [7:0]  data = 8'h00;
  logic [31:0] data_address = 32'h0;
  logic        tx, busy, fifo_full, overflow;
  logic [7:0]  drop_count;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          frames = 0;
  int          exp_frames = 0;
  int          start_prev = -1;
  int          start_last = -1;
  bit          mon_en = 1'b0;
  logic [7:0]  sb [$];

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  d;
    logic        hit;
  } vec_t;

  vec_t vecs [NVEC];

  mmio_uart_tx #(
    .MMIO_ADDR    (ADDR),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .data_write   (data_write),
    .data         (data),
    .data_address (data_address),
    .tx           (tx),
    .busy         (busy),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at a negedge; the store is sampled at the following posedge.
  task automatic write1(input logic we, input logic [31:0] addr, input logic [7:0] d);
    data_write   = we;
    data_address = addr;
    data         = d;
    @(posedge clk);
    @(negedge clk);
    data_write = 1'b0;
  endtask

  task automatic burst(input logic [7:0] first, input int n, input bit inc);
    for (int i = 0; i < n; i++) begin
      data_write   = 1'b1;
      data_address = ADDR;
      data         = inc ? 8'(first + 8'(i)) : first;
      @(posedge clk);
      @(negedge clk);
    end
    data_write = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", name, busy, budget);
    end
  endtask

  // UART receiver: samples each bit cell mid-way and checks against the scoreboard.
  initial begin : monitor
    logic [7:0] b;
    logic [7:0] e;
    b = '0;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && tx === 1'b0) begin
        start_prev = start_last;
        start_last = cyc;
        @(negedge clk);
        check("rx_start_bit", 32'(tx), 32'd0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          b[i] = tx;
          if (i < 7) repeat (CPB) @(negedge clk);
        end
        repeat (CPB) @(negedge clk);
        check("rx_stop_bit", 32'(tx), 32'd1);
        repeat (2) @(negedge clk);
        frames++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rx_unexpected: got frame %02h required none", b);
        end else begin
          e = sb.pop_front();
          check("rx_data", 32'(b), 32'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [7:0] v;
    logic       exp_bit;

    vecs[0] = '{1'b1, 32'hFFFF_0001, 8'hAA, 1'b0};
    vecs[1] = '{1'b0, 32'hFFFF_0000, 8'h5A, 1'b0};
    vecs[2] = '{1'b1, 32'h7FFF_0000, 8'h11, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFF_0000, 8'h00, 1'b1};
    vecs[4] = '{1'b1, 32'hFFFE_0000, 8'h22, 1'b0};
    vecs[5] = '{1'b1, 32'hFFFF_0000, 8'hFF, 1'b1};
    vecs[6] = '{1'b1, 32'h0000_0000, 8'h33, 1'b0};
    vecs[7] = '{1'b1, 32'hFFFF_0000, 8'h80, 1'b1};
    vecs[8] = '{1'b1, 32'hFFFF_8000, 8'h44, 1'b0};
    vecs[9] = '{1'b1, 32'hFFFF_0000, 8'h3C, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Async reset in the middle of a frame, with a dropped byte already recorded.
    burst(8'h01, 6, 1'b1);
    repeat (6) @(negedge clk);
    check("pre_rst_overflow", 32'(overflow), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_full", 32'(fifo_full), 32'd0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_drop", 32'(drop_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("postrst_tx", 32'(tx), 32'd1);
    mon_en = 1'b1;

    // Decode vectors: hits produce a frame, anything else leaves the line idle.
    for (int i = 0; i < int'(NVEC); i++) begin
      if (vecs[i].hit) begin
        sb.push_back(vecs[i].d);
        exp_frames++;
      end
      write1(vecs[i].we, vecs[i].addr, vecs[i].d);
      check("vec_busy", 32'(busy), 32'(vecs[i].hit));
      repeat (2) @(negedge clk);
      check("vec_tx", 32'(tx), 32'(!vecs[i].hit));
      check("vec_busy2", 32'(busy), 32'(vecs[i].hit));
      wait_idle("vec_idle", 100);
      check("vec_drained", 32'(sb.size()), 32'd0);
    end

    // Single byte 0x55: full waveform and busy timing.
    v = 8'h55;
    sb.push_back(v);
    exp_frames++;
    write1(1'b1, ADDR, v);
    check("single_busy_k", 32'(busy), 32'd1);
    check("single_tx_k", 32'(tx), 32'd1);
    repeat (2) @(negedge clk);
    for (int j = 0; j < 10; j++) begin
      if (j == 0)      exp_bit = 1'b0;
      else if (j == 9) exp_bit = 1'b1;
      else             exp_bit = v[j-1];
      check("single_cell", 32'(tx), 32'(exp_bit));
      if (j < 9) repeat (CPB) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    check("single_busy_k40", 32'(busy), 32'd1);
    @(negedge clk);
    check("single_busy_k41", 32'(busy), 32'd0);
    check("single_idle_tx", 32'(tx), 32'd1);

    // Back-to-back: second start bit directly follows the first stop bit.
    sb.push_back(8'h41);
    sb.push_back(8'h42);
    exp_frames += 2;
    burst(8'h41, 2, 1'b1);
    wait_idle("b2b_idle", 200);
    check("b2b_gap", 32'(start_last - start_prev), 32'(10 * CPB));
    check("b2b_drained", 32'(sb.size()), 32'd0);

    // Overflow: 01 leaves immediately, 02..05 fill the FIFO, 06 is dropped.
    for (int i = 1; i <= 5; i++) sb.push_back(8'(i));
    exp_frames += 5;
    burst(8'h01, 6, 1'b1);
    check("ovf_full", 32'(fifo_full), 32'd1);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drop", 32'(drop_count), 32'd1);
    wait_idle("ovf_idle", 400);
    check("ovf_drained", 32'(sb.size()), 32'd0);
    check("ovf_full_after", 32'(fifo_full), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Saturation: hammer the full FIFO; frame content is not tracked here.
    mon_en = 1'b0;
    burst(8'hC3, 300, 1'b0);
    check("sat_drop", 32'(drop_count), 32'd255);
    check("sat_flag", 32'(overflow), 32'd1);
    burst(8'hC3, 20, 1'b0);
    check("sat_drop_hold", 32'(drop_count), 32'd255);
    wait_idle("sat_idle", 400);
    check("sat_drop_idle", 32'(drop_count), 32'd255);
    check("sat_flag_idle", 32'(overflow), 32'd1);
    #3 reset = 1'b1;
    #1;
    check("sat_rst_drop", 32'(drop_count), 32'd0);
    check("sat_rst_flag", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("frame_count", 32'(frames), 32'(exp_frames));
    check("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped console transmitter. It sits on the CPU's byte-write output bus: data_write, data[7:0], data_address[31:0].
- Captures byte stores to one decoded address into a FIFO.
- Serializes each byte on a UART TX line as 8N1, LSB first.
- Gives the core program-visible console output without stalling the pipeline. Overflowing bytes are dropped and counted.

Parameters:
- MMIO_ADDR, 32'hFFFF_0000, byte address that the block decodes as the TX data register.
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200). Legal range 2..65535.
- FIFO_DEPTH, 16, FIFO entries. Must be a power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- data_write  in  1  CPU store strobe, one byte per asserted cycle
- data  in  8  store data byte
- data_address  in  32  store byte address
- tx  out  1  UART serial output, idles high
- busy  out  1  high while a frame is in flight or the FIFO is non-empty
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- overflow  out  1  sticky; set when any decoded write is dropped
- drop_count  out  8  saturating count of dropped bytes

Behaviour:
- Reset is asynchronous and active-high: it takes effect immediately, independent of clk.
  - Reset values: tx=1, busy=0, fifo_full=0, overflow=0, drop_count=0.
  - FIFO pointers and count are cleared; FSM returns to IDLE; baud and bit counters are cleared.
  - Reset mid-frame aborts the frame; tx returns high without waiting for a clock edge.
- Decode: a write is a hit when data_write=1 and data_address==MMIO_ADDR (full 32-bit compare). Non-hits are ignored entirely.
- Accept: on a hit with fifo_full=0 (pre-edge value), data is pushed at that rising edge.
- Drop: on a hit with fifo_full=1, the byte is discarded.
  - overflow is set.
  - drop_count increments and saturates at 255.
- Simultaneous hit and pop while full: the byte is still dropped. Full is judged on the pre-edge state.
- Simultaneous push and pop while not full: both occur; the count is unchanged.
- FIFO uses log2(FIFO_DEPTH)-bit pointers that wrap modulo depth, plus a count register sized to FIFO_DEPTH+1.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: at any edge where the FIFO is non-empty, pop the head into the shift register. Then go to START, reload the baud counter, and set tx=0 (registered).
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0 and tx=shreg[0].
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit 7 completes, go to STOP with tx=1.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles.
    - On completion, if the FIFO is non-empty, pop the head and go directly to START with tx=0 (no idle gap).
    - Otherwise go to IDLE.
- Latency: a byte accepted at edge k into an empty FIFO with the FSM in IDLE gives tx low from edge k+1.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Back-to-back frames are contiguous.
- busy = (state != IDLE) || (count != 0), registered-equivalent. busy goes high on the accepting edge.
- tx is driven from a flop; no combinational path from inputs to tx.

Decomposition:
- Shared package mmio_pkg holds:
  - the MMIO address map constant (MMIO_UART_ADDR = 32'hFFFF_0000), which the top level passes as MMIO_ADDR;
  - the tx_state_t enum {IDLE, START, DATA, STOP}.
- One sub-module, byte_fifo (parameter DEPTH).
  - Ports: clk, reset, push, din[7:0], pop, dout[7:0], full, empty.
  - Synchronous push/pop, first-word-through read: dout is valid whenever empty=0.
- The FSM, baud counter, decode and drop logic stay in mmio_uart_tx.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Reset behaviour: reset asserted mid-frame between clock edges.
  - Required: tx=1 and busy=0 immediately; overflow=0 and drop_count=0.
- Single byte: write 8'h55 to 32'hFFFF_0000 at edge k.
  - Required: tx=0 during cycles k+1..k+4.
  - Data bits 1,0,1,0,1,0,1,0, each held 4 cycles.
  - tx=1 stop bit during k+37..k+40; busy falls at edge k+41.
- Address filter: write 8'hAA to 32'hFFFF_0001, and separately assert data_address=32'hFFFF_0000 with data_write=0.
  - Required: tx stays 1, busy stays 0, FIFO empty.
- Back-to-back: write 8'h41 and 8'h42 on consecutive cycles.
  - Required: two contiguous 40-cycle frames; the start bit of 8'h42 immediately follows the stop bit of 8'h41.
- Overflow: write 6 bytes 8'h01..8'h06 on consecutive cycles.
  - Required: 8'h01 popped at the first edge; 8'h02..8'h05 fill the FIFO; fifo_full=1.
  - 8'h06 is dropped: overflow=1, drop_count=1.
  - Transmitted sequence is 01,02,03,04,05.
- Saturation: hold the FIFO full and issue 300 decoded writes.
  - Required: drop_count=255 and stays there; overflow=1 until reset.
